// File: rtl/mem_cmd_sequencer_if.sv
// Host/loader request, write-data stream, RAM command word and read-return stream
// for the memory command sequencer.
interface mem_cmd_sequencer_if #(
  parameter int BANK_W = 10,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 21
);
  logic              start;
  logic              mode;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [31:0]       cmd_address;
  logic [31:0]       cmd_data;
  logic [DATA_W-1:0] q;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  modport master (
    input  start, mode, bank, base_addr, count, s_valid, s_data, q,
    output busy, done, s_ready, cmd_address, cmd_data, r_valid, r_data
  );

  modport slave (
    output start, mode, bank, base_addr, count, s_valid, s_data, q,
    input  busy, done, s_ready, cmd_address, cmd_data, r_valid, r_data
  );
endinterface

// File: rtl/mem_cmd_sequencer.sv
// Turns a (bank, base, count) block request into one RAM command word per cycle,
// streaming write data in or returning read data as a valid-tagged stream.
module mem_cmd_sequencer #(
  parameter int BANK_W = 10,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 21,
  parameter int RD_LAT = 2
) (
  input logic                clk,
  input logic                reset,
  mem_cmd_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

  state_t            state;
  logic [BANK_W-1:0] bank_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  idx;
  logic [RD_LAT:0]   vld_pipe;
  logic [ADDR_W-1:0] addr_cur;
  logic              last;

  // Truncation to ADDR_W gives the modulo wrap at the top of the bank.
  assign addr_cur    = base_q + idx[ADDR_W-1:0];
  assign last        = (idx == cnt_q - 1'b1);
  assign bus.s_ready = (state == WRITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bank_q          <= '0;
      base_q          <= '0;
      cnt_q           <= '0;
      idx             <= '0;
      vld_pipe        <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.cmd_address <= '0;
      bus.cmd_data    <= '0;
      bus.r_valid     <= 1'b0;
      bus.r_data      <= '0;
    end else begin
      bus.done    <= 1'b0;
      // Bit RD_LAT marks a command whose RAM data is on q this cycle.
      bus.r_valid <= vld_pipe[RD_LAT];
      if (vld_pipe[RD_LAT]) bus.r_data <= bus.q;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], 1'b0};

      case (state)
        IDLE: begin
          bus.cmd_address[30] <= 1'b0;
          if (bus.start) begin
            bank_q   <= bus.bank;
            base_q   <= bus.base_addr;
            cnt_q    <= bus.count;
            idx      <= '0;
            bus.busy <= 1'b1;
            if (bus.count == '0) state <= FINISH;
            else                 state <= bus.mode ? READ : WRITE;
          end
        end
        WRITE: begin
          // A bubble still presents the current address, just with we low.
          bus.cmd_address <= {1'b0, bus.s_valid, bank_q, addr_cur};
          if (bus.s_valid) begin
            bus.cmd_data <= {{(32-DATA_W){1'b0}}, bus.s_data};
            idx          <= idx + 1'b1;
            if (last) state <= FINISH;
          end
        end
        READ: begin
          bus.cmd_address <= {1'b0, 1'b0, bank_q, addr_cur};
          vld_pipe        <= {vld_pipe[RD_LAT-1:0], 1'b1};
          idx             <= idx + 1'b1;
          if (last) state <= DRAIN;
        end
        DRAIN: begin
          bus.cmd_address[30] <= 1'b0;
          // Leave once only the final beat is left to emerge this edge.
          if (vld_pipe[RD_LAT-1:0] == '0) state <= FINISH;
        end
        FINISH: begin
          bus.cmd_address[30] <= 1'b0;
          bus.done            <= 1'b1;
          bus.busy            <= 1'b0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Randomized scoreboard bench for mem_cmd_sequencer with a behavioural banked RAM.
module tb_mem_cmd_sequencer;
  localparam int BANK_W = 10, ADDR_W = 20, DATA_W = 16, CNT_W = 21, RD_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_cmd_sequencer_if #(.BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

  mem_cmd_sequencer #(.BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
                      .RD_LAT(RD_LAT)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t wq[$];
  ev_t cq[$];
  ev_t rq[$];
  int  dq[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: banks alias on their low two bits, 1K words each.
  logic [15:0] ram [4096];
  logic [15:0] ref_mem [4096];
  logic [29:0] rd_a;

  function automatic int ridx(logic [29:0] a);
    return int'({a[21:20], a[9:0]});
  endfunction

  function automatic logic [15:0] init_word(int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (bus.cmd_address[30]) ram[ridx(bus.cmd_address[29:0])] <= bus.cmd_data[15:0];
    rd_a  <= bus.cmd_address[29:0];
    bus.q <= ram[ridx(rd_a)];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  dc;
    if (!reset) begin
      if (bus.cmd_address[31]) chk("bit31", {31'b0, bus.cmd_address[31]}, 32'd0);
      if (bus.cmd_address[30]) begin
        if (wq.size() == 0) chk("unexpected_write", bus.cmd_address, 32'd0);
        else begin
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", bus.cmd_address, e.a);
          chk("wr_data", bus.cmd_data, e.d);
        end
      end
      if (cq.size() != 0 && cq[0].cyc == cyc) begin
        e = cq.pop_front();
        chk("rd_cmd", bus.cmd_address, e.a);
      end
      if (bus.r_valid) begin
        if (rq.size() == 0) chk("unexpected_rvalid", {16'b0, bus.r_data}, 32'd0);
        else begin
          e = rq.pop_front();
          chk("rv_cycle", cyc, e.cyc);
          chk("r_data", {16'b0, bus.r_data}, e.d);
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) chk("unexpected_done", cyc, 32'd0);
        else begin
          dc = dq.pop_front();
          chk("done_cycle", cyc, dc);
          chk("busy_at_done", {31'b0, bus.busy}, 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit md, input logic [9:0] bk, input logic [19:0] ba, input int n,
                       output int s);
    bus.start     = 1'b1;
    bus.mode      = md;
    bus.bank      = bk;
    bus.base_addr = ba;
    bus.count     = CNT_W'(n);
    step();
    bus.start = 1'b0;
    s = cyc;
    chk("busy_rise", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic mid_start();
    bus.start     = 1'b1;
    bus.mode      = 1'($urandom);
    bus.bank      = 10'($urandom);
    bus.base_addr = 20'($urandom);
    bus.count     = CNT_W'($urandom_range(1, 5));
  endtask

  // gap: 0 = continuous, 1 = random, 2 = fixed 1,0,1,1,0,1 pattern
  task automatic do_write(input logic [9:0] bk, input logic [19:0] ba, input int n, input int gap,
                          input bit seqd, input bit mid);
    int          s, done_at, i, j;
    logic [5:0]  pat;
    logic [19:0] a;
    pat = 6'b101101;
    issue(1'b0, bk, ba, n, s);
    done_at = s + 1;
    i = 0;
    j = 0;
    while (i < n) begin
      chk("s_ready_write", {31'b0, bus.s_ready}, 32'd1);
      case (gap)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = ($urandom_range(0, 2) != 0);
        default: bus.s_valid = (j < 6) ? pat[j] : 1'b1;
      endcase
      bus.s_data = seqd ? 16'(16'hA001 + i) : 16'($urandom);
      if (mid && j == 1) mid_start();
      step();
      bus.start = 1'b0;
      if (bus.s_valid) begin
        a = 20'(ba + i);
        wq.push_back('{cyc, {2'b01, bk, a}, {16'b0, bus.s_data}});
        ref_mem[ridx({bk, a})] = bus.s_data;
        done_at = cyc + 1;
        i++;
      end
      j++;
    end
    bus.s_valid = 1'b0;
    dq.push_back(done_at);
    if (n > 0) chk("s_ready_after", {31'b0, bus.s_ready}, 32'd0);
    repeat (2) step();
  endtask

  task automatic do_read(input logic [9:0] bk, input logic [19:0] ba, input int n, input bit mid);
    int          s;
    logic [19:0] a;
    issue(1'b1, bk, ba, n, s);
    for (int i = 0; i < n; i++) begin
      a = 20'(ba + i);
      cq.push_back('{s + 1 + i, {2'b00, bk, a}, 32'd0});
      rq.push_back('{s + RD_LAT + 2 + i, 32'd0, {16'b0, ref_mem[ridx({bk, a})]}});
    end
    dq.push_back(s + n + RD_LAT + 2);
    if (mid) begin
      mid_start();
      step();
      bus.start = 1'b0;
    end
    while (cyc < s + n + RD_LAT + 4) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    bus.start = 1'b0; bus.mode = 1'b0; bus.bank = '0; bus.base_addr = '0; bus.count = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    reset = 1'b1;
    #2;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_cmd_address", bus.cmd_address, 32'd0);
    chk("rst_r_valid", {31'b0, bus.r_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Directed cases from the plan.
    do_write(10'd1, 20'h00010, 4, 0, 1'b1, 1'b0);
    do_write(10'd1, 20'h00010, 4, 2, 1'b1, 1'b0);
    do_write(10'd0, 20'h00100, 3, 0, 1'b0, 1'b0);
    ref_mem[ridx({10'd0, 20'h00100})] = 16'h1111;
    ref_mem[ridx({10'd0, 20'h00101})] = 16'h2222;
    ref_mem[ridx({10'd0, 20'h00102})] = 16'h3333;
    ram[ridx({10'd0, 20'h00100})] = 16'h1111;
    ram[ridx({10'd0, 20'h00101})] = 16'h2222;
    ram[ridx({10'd0, 20'h00102})] = 16'h3333;
    do_read(10'd0, 20'h00100, 3, 1'b0);
    do_read(10'd2, 20'hFFFFE, 4, 1'b0);
    do_write(10'd3, 20'h00040, 0, 0, 1'b0, 1'b0);
    do_read(10'd1, 20'h00020, 5, 1'b1);
    do_write(10'd2, 20'h00030, 5, 0, 1'b0, 1'b1);

    // Reset during the third beat of an 8-word write; no done may follow.
    issue(1'b0, 10'd0, 20'h00300, 8, s);
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'($urandom);
      step();
      wq.push_back('{cyc, {2'b01, 10'd0, 20'(20'h00300 + i)}, {16'b0, bus.s_data}});
    end
    bus.s_data = 16'hBEEF;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_done", {31'b0, bus.done}, 32'd0);
    chk("arst_s_ready", {31'b0, bus.s_ready}, 32'd0);
    chk("arst_cmd_address", bus.cmd_address, 32'd0);
    chk("arst_cmd_data", bus.cmd_data, 32'd0);
    chk("arst_r_valid", {31'b0, bus.r_valid}, 32'd0);
    chk("arst_r_data", {16'b0, bus.r_data}, 32'd0);
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk("no_done_after_reset", dq.size(), 32'd0);
    do_write(10'd1, 20'h00050, 3, 0, 1'b0, 1'b0);
    do_read(10'd1, 20'h00050, 3, 1'b0);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      logic [9:0]  bk;
      logic [19:0] ba;
      int          n;
      bk = 10'($urandom_range(0, 3));
      ba = 20'($urandom_range(0, 20'h1F0));
      n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      if (n != 0 && $urandom_range(0, 1) == 1) do_read(bk, ba, n, 1'($urandom));
      else do_write(bk, ba, n, 1, 1'b0, 1'($urandom));
    end

    repeat (10) step();
    chk("wq_left", wq.size(), 32'd0);
    chk("cq_left", cq.size(), 32'd0);
    chk("rq_left", rq.size(), 32'd0);
    chk("dq_left", dq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
